// File: rtl/zb_chip_spreader_pkg.sv
// zb_chip_pkg: shared constants, types and the chip-table rule for the
// 802.15.4 O-QPSK direct-sequence spreader.
//   CHIPS_PER_SYM  : chips emitted per 4-bit symbol
//   SYM0_CHIPS     : PN sequence of symbol 0, bit i = chip ci
//   spread_state_t : spreader control state
//   chip_seq()     : 4-bit symbol -> 32-bit chip vector (bit i = chip ci)
package zb_chip_pkg;

    localparam int CHIPS_PER_SYM = 32;

    // c0..c31 = 11011001110000110101001000101110, stored with c0 in bit 0.
    localparam logic [31:0] SYM0_CHIPS = 32'h744A_C39B;

    typedef enum logic {
        IDLE   = 1'b0,
        SPREAD = 1'b1
    } spread_state_t;

    // Symbols 0..7 are symbol 0 rotated towards later chips by 4 per step;
    // symbols 8..15 reuse those with every odd-indexed chip inverted.
    function automatic logic [31:0] chip_seq(input logic [3:0] sym);
        logic [31:0] rot;
        logic [4:0]  shift;
        logic [4:0]  src;
        shift = {sym[2:0], 2'b00};
        for (int i = 0; i < CHIPS_PER_SYM; i++) begin
            // 5-bit subtraction wraps, giving the modulo-32 source index.
            src    = 5'(i) - shift;
            rot[i] = SYM0_CHIPS[src];
        end
        if (sym[3]) begin
            rot = rot ^ 32'hAAAA_AAAA;
        end
        return rot;
    endfunction

endpackage

// File: rtl/zb_chip_spreader_if.sv
// zb_chip_spreader_if: symbol input handshake plus serial chip output.
//   master : upstream/bench side (drives symbol, valid and chip strobe)
//   slave  : spreader side
//   inSymbol[3:0], inValid, outReady : symbol transfer on inValid && outReady
//   inChipEn                         : chip-rate strobe
//   outChip, outChipValid            : registered chip stream
//   outSymStart                      : pulse on chip c0 of each symbol
//   outBusy                          : spreading or a symbol is held
interface zb_chip_spreader_if;
    logic [3:0] inSymbol;
    logic       inValid;
    logic       outReady;
    logic       inChipEn;
    logic       outChip;
    logic       outChipValid;
    logic       outSymStart;
    logic       outBusy;

    modport master (
        output inSymbol, inValid, inChipEn,
        input  outReady, outChip, outChipValid, outSymStart, outBusy
    );

    modport slave (
        input  inSymbol, inValid, inChipEn,
        output outReady, outChip, outChipValid, outSymStart, outBusy
    );
endinterface

// File: rtl/zb_chip_spreader_rom.sv
// zb_chip_rom: combinational chip table.
//   inSymbol[3:0]  : symbol to look up
//   outChips[31:0] : its 32-chip PN sequence, bit i = chip ci
module zb_chip_rom
    import zb_chip_pkg::*;
(
    input  logic [3:0]  inSymbol,
    output logic [31:0] outChips
);
    assign outChips = chip_seq(inSymbol);
endmodule

// File: rtl/zb_chip_spreader.sv
// zb_chip_spreader: maps each 4-bit symbol to its 32-chip sequence and emits
// the chips serially, one per inChipEn strobe. A one-entry holding register
// lets the next symbol be accepted while the current one is spreading, so
// consecutive symbols follow without a gap.
//   inClock : clock, rising edge
//   inReset : synchronous active-high reset
//   bus     : zb_chip_spreader_if.slave (see interface file)
module zb_chip_spreader
    import zb_chip_pkg::*;
(
    input  logic                  inClock,
    input  logic                  inReset,
    zb_chip_spreader_if.slave     bus
);
    localparam logic [4:0] LAST_IDX = 5'(CHIPS_PER_SYM - 1);

    spread_state_t stateReg, stateNext;

    logic [3:0]  holdSymReg,   holdSymNext;
    logic        holdValidReg, holdValidNext;
    logic [3:0]  actSymReg,    actSymNext;
    logic [4:0]  chipIdxReg,   chipIdxNext;
    logic        chipReg,      chipNext;
    logic        chipValidReg, chipValidNext;
    logic        symStartReg,  symStartNext;

    logic        accept;
    logic        reloadSel;
    logic        reload;
    logic [3:0]  romSym;
    logic [31:0] romChips;

    // A held symbol is due to become active when nothing is spreading or the
    // last chip of the current one is on the output. The single ROM looks at
    // the held symbol in that case so c0 is available on the reload edge.
    assign accept    = bus.inValid && !holdValidReg && !inReset;
    assign reloadSel = holdValidReg && ((stateReg == IDLE) || (chipIdxReg == LAST_IDX));
    assign reload    = reloadSel && bus.inChipEn;
    assign romSym    = reloadSel ? holdSymReg : actSymReg;

    zb_chip_rom romInst (
        .inSymbol (romSym),
        .outChips (romChips)
    );

    // State register
    always_ff @(posedge inClock) begin
        if (inReset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        if (reload) begin
            stateNext = SPREAD;
        end else if (stateReg == SPREAD && bus.inChipEn && chipIdxReg == LAST_IDX) begin
            stateNext = IDLE;
        end
    end

    // Output logic
    always_comb begin
        bus.outReady     = !holdValidReg && !inReset;
        bus.outBusy      = (stateReg == SPREAD) || holdValidReg;
        bus.outChip      = chipReg;
        bus.outChipValid = chipValidReg;
        bus.outSymStart  = symStartReg;
    end

    // Datapath registers
    always_ff @(posedge inClock) begin
        if (inReset) begin
            holdSymReg   <= '0;
            holdValidReg <= 1'b0;
            actSymReg    <= '0;
            chipIdxReg   <= '0;
            chipReg      <= 1'b0;
            chipValidReg <= 1'b0;
            symStartReg  <= 1'b0;
        end else begin
            holdSymReg   <= holdSymNext;
            holdValidReg <= holdValidNext;
            actSymReg    <= actSymNext;
            chipIdxReg   <= chipIdxNext;
            chipReg      <= chipNext;
            chipValidReg <= chipValidNext;
            symStartReg  <= symStartNext;
        end
    end

    // Datapath next values. accept needs an empty holding register and
    // reload needs a full one, so they never fire on the same edge.
    always_comb begin
        holdSymNext   = holdSymReg;
        holdValidNext = holdValidReg;
        actSymNext    = actSymReg;
        chipIdxNext   = chipIdxReg;
        chipNext      = chipReg;
        chipValidNext = chipValidReg;
        symStartNext  = 1'b0;

        if (accept) begin
            holdSymNext   = bus.inSymbol;
            holdValidNext = 1'b1;
        end

        if (reload) begin
            actSymNext    = holdSymReg;
            holdValidNext = 1'b0;
            chipIdxNext   = '0;
            chipNext      = romChips[0];
            chipValidNext = 1'b1;
            symStartNext  = 1'b1;
        end else if (stateReg == SPREAD && bus.inChipEn) begin
            if (chipIdxReg != LAST_IDX) begin
                chipIdxNext = chipIdxReg + 5'd1;
                chipNext    = romChips[chipIdxReg + 5'd1];
            end else begin
                chipNext      = 1'b0;
                chipValidNext = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zb_chip_spreader.sv
module tb_zb_chip_spreader;

    logic inClock = 1'b0;
    logic inReset = 1'b1;
    always #5 inClock = ~inClock;

    zb_chip_spreader_if bus();

    zb_chip_spreader dut (
        .inClock (inClock),
        .inReset (inReset),
        .bus     (bus.slave)
    );

    typedef struct {
        logic chip;
        logic first;
        int   acceptCycle;
    } exp_t;

    exp_t q[$];
    int   startCycles[$];
    int   testCount  = 0;
    int   failCount  = 0;
    int   cycleCnt   = 0;
    int   chipsSeen  = 0;
    int   enMode     = 0;
    int   enPhase    = 0;
    logic enAtEdge   = 1'b0;
    logic lastChip   = 1'b0;

    // Reference vectors written c0 first (MSB = c0).
    logic [31:0] SYM0_REF = 32'b11011001110000110101001000101110;
    logic [31:0] SYM1_REF = 32'b11101101100111000011010100100010;
    logic [31:0] SYM9_REF = 32'b10111000110010010110000001110111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model, MSB-first: chip i of symbol k is symbol-0 chip
    // (i - 4k) mod 32, odd chips inverted for k >= 8.
    function automatic logic [31:0] refChips(input int k);
        logic [31:0] s0;
        logic [31:0] r;
        int src;
        logic b;
        s0 = SYM0_REF;
        for (int i = 0; i < 32; i++) begin
            src = (i - 4 * (k % 8) + 64) % 32;
            b = s0[31 - src];
            if (k >= 8 && (i % 2) == 1) b = ~b;
            r[31 - i] = b;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge inClock);
            #1;
        end
    endtask

    task automatic sendSym(input logic [3:0] sym, input logic [31:0] vec);
        int n;
        exp_t e;
        n = 0;
        bus.inSymbol = sym;
        bus.inValid  = 1'b1;
        while (!bus.outReady && n < 500) begin
            @(posedge inClock);
            #1;
            n++;
        end
        check("accept_timeout", 32'(n < 500), 32'd1);
        if (n < 500) begin
            for (int i = 0; i < 32; i++) begin
                e.chip        = vec[31 - i];
                e.first       = (i == 0);
                e.acceptCycle = cycleCnt + 1;
                q.push_back(e);
            end
            $display("[TB] symbol %0d accepted at cycle %0d", sym, cycleCnt + 1);
        end
        @(posedge inClock);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((bus.outBusy || bus.outChipValid) && n < 1000) begin
            @(posedge inClock);
            #1;
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 1000), 32'd1);
        check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
        check({tag, "_valid_low"}, 32'(bus.outChipValid), 32'd0);
        check({tag, "_busy_low"}, 32'(bus.outBusy), 32'd0);
    endtask

    // Output monitor: pops one expected chip for every strobed edge at which
    // the head symbol has already been accepted.
    initial begin
        exp_t e;
        @(posedge inClock);
        forever begin
            @(negedge inClock);
            if (enAtEdge) begin
                if (q.size() > 0 && q[0].acceptCycle < cycleCnt) begin
                    e = q.pop_front();
                    check("chip_valid", 32'(bus.outChipValid), 32'd1);
                    check("chip_value", 32'(bus.outChip), 32'(e.chip));
                    check("sym_start", 32'(bus.outSymStart), 32'(e.first));
                    chipsSeen++;
                    lastChip = e.chip;
                    if (e.first) startCycles.push_back(cycleCnt);
                end else begin
                    check("idle_valid", 32'(bus.outChipValid), 32'd0);
                    check("idle_chip", 32'(bus.outChip), 32'd0);
                    check("idle_sym_start", 32'(bus.outSymStart), 32'd0);
                end
            end else begin
                check("hold_sym_start", 32'(bus.outSymStart), 32'd0);
                if (bus.outChipValid) check("hold_chip", 32'(bus.outChip), 32'(lastChip));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.inSymbol = 4'd0;
        bus.inValid  = 1'b0;
        bus.inChipEn = 1'b0;
        inReset      = 1'b1;

        // Chip strobe generator; also tracks which edges carried a strobe.
        fork
            forever begin
                @(posedge inClock);
                cycleCnt++;
                enAtEdge = bus.inChipEn && !inReset;
                #1;
                enPhase++;
                case (enMode)
                    0:       bus.inChipEn = 1'b1;
                    1:       bus.inChipEn = (enPhase % 4 == 0);
                    default: bus.inChipEn = 1'b0;
                endcase
            end
        join_none

        // Reset state
        tick(5);
        check("rst_chip", 32'(bus.outChip), 32'd0);
        check("rst_valid", 32'(bus.outChipValid), 32'd0);
        check("rst_sym_start", 32'(bus.outSymStart), 32'd0);
        check("rst_busy", 32'(bus.outBusy), 32'd0);
        check("rst_ready", 32'(bus.outReady), 32'd0);
        inReset = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.outReady), 32'd1);
        tick(1);

        // Single symbols, continuous strobe
        sendSym(4'd0, SYM0_REF);
        waitIdle("sym0");
        sendSym(4'd1, SYM1_REF);
        waitIdle("sym1");
        sendSym(4'd9, SYM9_REF);
        waitIdle("sym9");

        // Back-to-back 3 then 12, plus a dropped symbol while full
        startCycles.delete();
        sendSym(4'd3, refChips(3));
        sendSym(4'd12, refChips(12));
        tick(3);
        check("b2b_ready_low", 32'(bus.outReady), 32'd0);
        bus.inSymbol = 4'd7;
        bus.inValid  = 1'b1;
        tick(1);
        bus.inValid  = 1'b0;
        check("drop_ready_low", 32'(bus.outReady), 32'd0);
        waitIdle("b2b");
        check("b2b_start_count", 32'(startCycles.size()), 32'd2);
        if (startCycles.size() == 2)
            check("b2b_start_gap", 32'(startCycles[1] - startCycles[0]), 32'd32);
        $display("[TB] back-to-back done, %0d symbol starts", startCycles.size());

        // 1-in-4 strobe
        enMode = 1;
        tick(2);
        sendSym(4'd10, refChips(10));
        sendSym(4'd2, refChips(2));
        waitIdle("slow");
        enMode = 0;
        tick(2);

        // Reset at chip 10 of symbol 5 with symbol 6 held
        base = chipsSeen;
        sendSym(4'd5, refChips(5));
        sendSym(4'd6, refChips(6));
        n = 0;
        while (chipsSeen < base + 11 && n < 200) begin
            @(negedge inClock);
            #2;
            n++;
        end
        check("rst_mid_timeout", 32'(n < 200), 32'd1);
        inReset = 1'b1;
        q.delete();
        @(posedge inClock);
        #1;
        check("mid_rst_chip", 32'(bus.outChip), 32'd0);
        check("mid_rst_valid", 32'(bus.outChipValid), 32'd0);
        check("mid_rst_busy", 32'(bus.outBusy), 32'd0);
        check("mid_rst_ready", 32'(bus.outReady), 32'd0);
        tick(1);
        inReset = 1'b0;
        #1;
        check("mid_rst_ready_after", 32'(bus.outReady), 32'd1);
        tick(100);
        check("post_rst_busy", 32'(bus.outBusy), 32'd0);
        check("post_rst_valid", 32'(bus.outChipValid), 32'd0);
        $display("[TB] reset-mid-symbol done");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
